seq_detect_scheduler: RTL

Shares one bit-serial 10110 sequence detector among NUM_REQ requesters. Each requester offers a parallel WORD_W-bit word. A round-robin arbiter grants one word at a time. The word is serialised MSB-first into the detector, and the detector's match pulses are counted. A per-word result (requester id, match count) is returned on a valid/ready channel, and the detector is restarted between words so that no state carries across them.

---
 rtl/seq_detect_scheduler.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that shares one external bit-serial 10110 detector among NUM_REQ requesters.
// Optional macro SEQ_SCHED_FIRST_POS_EN adds res_first_pos (bit index of the first match in the word).
module seq_detect_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WORD_W  = 8,
  parameter int CNT_W   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WORD_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         det_seq,
  output logic                         det_valid,
  input  logic                         det_detected,
  output logic                         det_restart,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
`ifdef SEQ_SCHED_FIRST_POS_EN
  output logic [$clog2(WORD_W):0]      res_first_pos,
`endif
  output logic [CNT_W-1:0]             res_count
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
`ifdef SEQ_SCHED_FIRST_POS_EN
  localparam int POS_W = $clog2(WORD_W) + 1;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, RESULT, FLUSH} state_t;

  state_t              state, state_d;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
  logic [WORD_W-1:0]   shreg, shreg_d;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [CNT_W-1:0]    count, count_d;
  logic [NUM_REQ-1:0]  req_ready_d;
  logic                det_valid_d;
  logic                res_valid_d;
  logic [ID_W-1:0]     res_id_d;
  logic [CNT_W-1:0]    res_count_d;
  logic                gnt_found;
  logic [ID_W-1:0]     gnt_id;
  logic [WORD_W-1:0]   words [NUM_REQ];
`ifdef SEQ_SCHED_FIRST_POS_EN
  logic [POS_W-1:0]    first_pos, first_pos_d, res_first_pos_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign words[g] = req_data[g*WORD_W +: WORD_W];
  end

  assign det_seq     = shreg[WORD_W-1];
  assign det_restart = reset | (state == FLUSH);

  // Scan downwards so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(rr_ptr, i)]) begin
        gnt_found = 1'b1;
        gnt_id    = rr_index(rr_ptr, i);
      end
    end
  end

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    shreg_d     = shreg;
    bit_cnt_d   = bit_cnt;
    count_d     = count;
    req_ready_d = '0;
    det_valid_d = det_valid;
    res_valid_d = res_valid;
    res_id_d    = res_id;
    res_count_d = res_count;
`ifdef SEQ_SCHED_FIRST_POS_EN
    first_pos_d     = first_pos;
    res_first_pos_d = res_first_pos;
`endif
    case (state)
      IDLE: begin
        if (gnt_found) begin
          state_d             = SHIFT;
          req_ready_d[gnt_id] = 1'b1;
          shreg_d             = words[gnt_id];
          res_id_d            = gnt_id;
          count_d             = '0;
          bit_cnt_d           = '0;
          det_valid_d         = 1'b1;
`ifdef SEQ_SCHED_FIRST_POS_EN
          first_pos_d         = '1;
`endif
        end
      end
      SHIFT: begin
        shreg_d   = shreg << 1;
        bit_cnt_d = bit_cnt + BIT_W'(1);
        if (det_detected) begin
          count_d = sat_inc(count);
`ifdef SEQ_SCHED_FIRST_POS_EN
          if (first_pos == '1) first_pos_d = POS_W'(bit_cnt);
`endif
        end
        // The result snapshot must include a match reported on the final bit.
        if (bit_cnt == LAST_BIT) begin
          state_d     = RESULT;
          det_valid_d = 1'b0;
          res_valid_d = 1'b1;
          res_count_d = count_d;
`ifdef SEQ_SCHED_FIRST_POS_EN
          res_first_pos_d = first_pos_d;
`endif
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d     = FLUSH;
          res_valid_d = 1'b0;
        end
      end
      FLUSH: begin
        state_d  = IDLE;
        rr_ptr_d = (res_id == ID_W'(NUM_REQ - 1)) ? '0 : res_id + ID_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      count     <= '0;
      req_ready <= '0;
      det_valid <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_count <= '0;
`ifdef SEQ_SCHED_FIRST_POS_EN
      first_pos     <= '1;
      res_first_pos <= '1;
`endif
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      count     <= count_d;
      req_ready <= req_ready_d;
      det_valid <= det_valid_d;
      res_valid <= res_valid_d;
      res_id    <= res_id_d;
      res_count <= res_count_d;
`ifdef SEQ_SCHED_FIRST_POS_EN
      first_pos     <= first_pos_d;
      res_first_pos <= res_first_pos_d;
`endif
    end
  end

endmodule
